// File: rtl/comp_frame_decoder_if.sv
// Capture-FIFO side and result-stream side of comp_frame_decoder, bundled as one interface.
// The master modport drives the FIFO and downstream-ready; the slave modport is the decoder.
interface comp_frame_decoder_if #(
  parameter int unsigned CONV_BITS = 17
);
  logic                 enable;
  logic                 clear;
  logic [31:0]          fifo_data;
  logic                 fifo_empty;
  logic                 fifo_read;
  logic [CONV_BITS-1:0] conv_data;
  logic [11:0]          conv_frame;
  logic                 conv_valid;
  logic                 conv_ready;
  logic [15:0]          id_err_cnt;
  logic [15:0]          seq_err_cnt;
  logic [15:0]          gap_cnt;

  modport master (
    output enable, clear, fifo_data, fifo_empty, conv_ready,
    input  fifo_read, conv_data, conv_frame, conv_valid, id_err_cnt, seq_err_cnt, gap_cnt
  );

  modport slave (
    input  enable, clear, fifo_data, fifo_empty, conv_ready,
    output fifo_read, conv_data, conv_frame, conv_valid, id_err_cnt, seq_err_cnt, gap_cnt
  );
endinterface

// File: rtl/comp_frame_decoder.sv
// Reassembles head/tail FIFO word pairs into one CONV_BITS-wide conversion on a valid/ready stream.
// Define COMP_DEC_STATS_EN to build the saturating id/sequence/gap error counters.
module comp_frame_decoder #(
  parameter logic [3:0]  IDENTIFIER = 4'b0001,
  parameter int unsigned CONV_BITS  = 17
) (
  input logic                  bus_clk,
  input logic                  bus_rst,
  comp_frame_decoder_if.slave  bus
);

  typedef enum logic [1:0] {StWaitHead, StWaitTail, StOutHold} state_e;

  state_e               state_q, state_d;
  logic [15:0]          head_q, head_d;
  logic [11:0]          frame_q, frame_d;
  logic [CONV_BITS-1:0] conv_data_q, conv_data_d;
  logic [11:0]          conv_frame_q, conv_frame_d;
  logic                 conv_valid_q, conv_valid_d;

  logic        pop;
  logic        id_ok;
  logic        frame_match;
  logic        assemble;
  logic [11:0] word_frame;

  assign word_frame  = bus.fifo_data[27:16];
  assign id_ok       = (bus.fifo_data[31:28] == IDENTIFIER);
  assign frame_match = (word_frame == frame_q);
  // Clear and reset both suppress the pop so no word is lost while state is being dropped.
  assign pop         = bus.enable & ~bus.fifo_empty & (state_q != StOutHold) & ~bus.clear & ~bus_rst;
  assign assemble    = pop & id_ok & frame_match & (state_q == StWaitTail);

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    frame_d      = frame_q;
    conv_data_d  = conv_data_q;
    conv_frame_d = conv_frame_q;
    conv_valid_d = conv_valid_q;
    if (bus.clear) begin
      state_d      = StWaitHead;
      conv_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StWaitHead: begin
          if (pop && id_ok) begin
            head_d  = bus.fifo_data[15:0];
            frame_d = word_frame;
            state_d = StWaitTail;
          end
        end
        StWaitTail: begin
          if (pop && id_ok) begin
            if (frame_match) begin
              conv_data_d  = {head_q, bus.fifo_data[CONV_BITS-17:0]};
              conv_frame_d = frame_q;
              conv_valid_d = 1'b1;
              state_d      = StOutHold;
            end else begin
              // Orphaned head: the mismatching word restarts the pair.
              head_d  = bus.fifo_data[15:0];
              frame_d = word_frame;
            end
          end
        end
        StOutHold: begin
          if (bus.conv_ready) begin
            conv_valid_d = 1'b0;
            state_d      = StWaitHead;
          end
        end
        default: state_d = StWaitHead;
      endcase
    end
  end

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      state_q      <= StWaitHead;
      head_q       <= '0;
      frame_q      <= '0;
      conv_data_q  <= '0;
      conv_frame_q <= '0;
      conv_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      frame_q      <= frame_d;
      conv_data_q  <= conv_data_d;
      conv_frame_q <= conv_frame_d;
      conv_valid_q <= conv_valid_d;
    end
  end

  assign bus.fifo_read  = pop;
  assign bus.conv_data  = conv_data_q;
  assign bus.conv_frame = conv_frame_q;
  assign bus.conv_valid = conv_valid_q;

`ifdef COMP_DEC_STATS_EN
  logic [15:0] id_err_q, id_err_d;
  logic [15:0] seq_err_q, seq_err_d;
  logic [15:0] gap_q, gap_d;
  logic [11:0] prev_frame_q, prev_frame_d;
  logic        prev_valid_q, prev_valid_d;

  always_comb begin
    id_err_d     = id_err_q;
    seq_err_d    = seq_err_q;
    gap_d        = gap_q;
    prev_frame_d = prev_frame_q;
    prev_valid_d = prev_valid_q;
    if (bus.clear) begin
      id_err_d     = '0;
      seq_err_d    = '0;
      gap_d        = '0;
      prev_valid_d = 1'b0;
    end else begin
      if (pop && !id_ok && id_err_q != 16'hFFFF) id_err_d = id_err_q + 16'd1;
      if (pop && id_ok && state_q == StWaitTail && !frame_match && seq_err_q != 16'hFFFF) begin
        seq_err_d = seq_err_q + 16'd1;
      end
      if (assemble) begin
        // 12-bit add wraps, so 4095 -> 0 counts as consecutive.
        if (prev_valid_q && frame_q != prev_frame_q + 12'd1 && gap_q != 16'hFFFF) begin
          gap_d = gap_q + 16'd1;
        end
        prev_frame_d = frame_q;
        prev_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      id_err_q     <= '0;
      seq_err_q    <= '0;
      gap_q        <= '0;
      prev_frame_q <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      id_err_q     <= id_err_d;
      seq_err_q    <= seq_err_d;
      gap_q        <= gap_d;
      prev_frame_q <= prev_frame_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  assign bus.id_err_cnt  = id_err_q;
  assign bus.seq_err_cnt = seq_err_q;
  assign bus.gap_cnt     = gap_q;
`else
  assign bus.id_err_cnt  = '0;
  assign bus.seq_err_cnt = '0;
  assign bus.gap_cnt     = '0;
`endif

endmodule

// File: tb/tb_comp_frame_decoder.sv
// Scoreboard bench for comp_frame_decoder: a queue-modelled FWFT FIFO feeds word pairs, expected
// results are queued on push and compared on each valid/ready handshake.
module tb_comp_frame_decoder;
  localparam int unsigned CB = 17;

  typedef struct {
    logic [31:0] data;
    logic [11:0] frame;
  } exp_t;

  logic        bus_clk;
  logic        bus_rst;
  logic [31:0] fq[$];
  exp_t        sb[$];
  int unsigned n_checks;
  int unsigned n_fail;
  logic        last_pop;

  comp_frame_decoder_if #(.CONV_BITS(CB)) ifc ();

  comp_frame_decoder #(.IDENTIFIER(4'b0001), .CONV_BITS(CB)) dut (
    .bus_clk (bus_clk),
    .bus_rst (bus_rst),
    .bus     (ifc)
  );

  initial begin
    bus_clk = 1'b0;
    forever #5 bus_clk = ~bus_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected counter value: zero when the statistics block is not built.
  function automatic logic [31:0] st(input int unsigned v);
`ifdef COMP_DEC_STATS_EN
    return 32'(v);
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  function automatic logic [31:0] mkw(input logic [3:0] id, input logic [11:0] fr,
                                      input logic [15:0] pl);
    return {id, fr, pl};
  endfunction

  task automatic fifo_refresh();
    ifc.fifo_empty = (fq.size() == 0);
    ifc.fifo_data  = (fq.size() != 0) ? fq[0] : 32'h0;
  endtask

  task automatic push_word(input logic [31:0] w);
    fq.push_back(w);
    fifo_refresh();
  endtask

  task automatic sb_push(input logic [11:0] fr, input logic [15:0] hd, input logic [15:0] tl);
    exp_t e;
    logic [31:0] mask;
    mask    = (32'd1 << (CB - 16)) - 32'd1;
    e.data  = ({16'h0, hd} << (CB - 16)) | ({16'h0, tl} & mask);
    e.frame = fr;
    sb.push_back(e);
  endtask

  task automatic push_pair(input logic [11:0] fr, input logic [15:0] hd, input logic [15:0] tl);
    push_word(mkw(4'h1, fr, hd));
    push_word(mkw(4'h1, fr, tl));
    sb_push(fr, hd, tl);
  endtask

  // One clock: sample pre-edge pop/handshake, advance, then update the FIFO model.
  task automatic tick();
    logic hs;
    exp_t e;
    #2;
    last_pop = ifc.fifo_read;
    hs       = ifc.conv_valid & ifc.conv_ready;
    if (hs) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_result", 32'(ifc.conv_frame), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check_eq("sb_data", 32'(ifc.conv_data), e.data);
        check_eq("sb_frame", 32'(ifc.conv_frame), 32'(e.frame));
      end
    end
    @(posedge bus_clk);
    #1;
    if (last_pop && fq.size() != 0) void'(fq.pop_front());
    fifo_refresh();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(sb.size()), 32'd0);
    repeat (4) tick();
  endtask

  task automatic pulse_clear();
    ifc.clear = 1'b1;
    tick();
    ifc.clear = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_pop = 1'b0;
    bus_rst  = 1'b1;
    ifc.enable     = 1'b0;
    ifc.clear      = 1'b0;
    ifc.conv_ready = 1'b1;
    fifo_refresh();
    repeat (2) @(posedge bus_clk);
    #1;
    check_eq("rst_valid", 32'(ifc.conv_valid), 32'd0);
    check_eq("rst_data", 32'(ifc.conv_data), 32'd0);
    check_eq("rst_frame", 32'(ifc.conv_frame), 32'd0);
    check_eq("rst_read", 32'(ifc.fifo_read), 32'd0);
    check_eq("rst_id", 32'(ifc.id_err_cnt), 32'd0);
    check_eq("rst_seq", 32'(ifc.seq_err_cnt), 32'd0);
    check_eq("rst_gap", 32'(ifc.gap_cnt), 32'd0);
    bus_rst    = 1'b0;
    ifc.enable = 1'b1;
    tick();

    // Basic decode and head/tail/valid latency.
    push_pair(12'd5, 16'hABCD, 16'h0001);
    tick();
    check_eq("t1_pop_head", 32'(last_pop), 32'd1);
    tick();
    check_eq("t1_pop_tail", 32'(last_pop), 32'd1);
    check_eq("t1_valid", 32'(ifc.conv_valid), 32'd1);
    check_eq("t1_data", 32'(ifc.conv_data), 32'h1579B);
    check_eq("t1_frame", 32'(ifc.conv_frame), 32'd5);
    drain("t1_drain");

    // Frame wrap is not a gap; skipping frames is.
    pulse_clear();
    push_pair(12'd4094, 16'h0102, 16'h0001);
    push_pair(12'd4095, 16'h0304, 16'h0000);
    push_pair(12'd0, 16'h0506, 16'h0001);
    drain("t2_drain");
    check_eq("t2_gap0", 32'(ifc.gap_cnt), st(0));
    push_pair(12'd3, 16'h0708, 16'h0000);
    drain("t2_drain_b");
    check_eq("t2_gap1", 32'(ifc.gap_cnt), st(1));

    // Foreign id between head and tail is dropped.
    pulse_clear();
    check_eq("clr_gap", 32'(ifc.gap_cnt), 32'd0);
    push_word(mkw(4'h1, 12'd7, 16'h1234));
    push_word(32'h2007_FFFF);
    push_word(mkw(4'h1, 12'd7, 16'h0000));
    sb_push(12'd7, 16'h1234, 16'h0000);
    drain("t3_drain");
    check_eq("t3_id", 32'(ifc.id_err_cnt), st(1));
    check_eq("t3_seq", 32'(ifc.seq_err_cnt), st(0));

    // Orphan head replaced by a newer head.
    pulse_clear();
    push_word(mkw(4'h1, 12'd9, 16'h1111));
    push_pair(12'd10, 16'h2222, 16'h0001);
    drain("t4_drain");
    check_eq("t4_seq", 32'(ifc.seq_err_cnt), st(1));
    check_eq("t4_id", 32'(ifc.id_err_cnt), st(0));

    // Back-pressure: hold output, no pops, then release in order.
    pulse_clear();
    ifc.conv_ready = 1'b0;
    push_pair(12'd100, 16'hBEEF, 16'h0001);
    push_pair(12'd101, 16'hCAFE, 16'h0000);
    begin
      int n;
      n = 0;
      while (!ifc.conv_valid && n < 10) begin
        tick();
        n++;
      end
    end
    check_eq("t5_valid", 32'(ifc.conv_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("t5_nopop", 32'(last_pop), 32'd0);
      check_eq("t5_data", 32'(ifc.conv_data), sb[0].data);
      check_eq("t5_frame", 32'(ifc.conv_frame), 32'(sb[0].frame));
    end
    check_eq("t5_depth", 32'(fq.size()), 32'd2);
    ifc.conv_ready = 1'b1;
    drain("t5_drain");
    check_eq("t5_gap", 32'(ifc.gap_cnt), st(0));

    // Clear between head and tail drops the partial frame.
    push_word(mkw(4'h1, 12'd20, 16'h5555));
    tick();
    tick();
    pulse_clear();
    push_pair(12'd21, 16'h6666, 16'h0001);
    drain("t6_drain");
    check_eq("t6_seq", 32'(ifc.seq_err_cnt), 32'd0);
    check_eq("t6_gap", 32'(ifc.gap_cnt), 32'd0);
    check_eq("t6_id", 32'(ifc.id_err_cnt), 32'd0);

    // Reset between head and tail does the same, and forgets the previous frame.
    push_word(mkw(4'h1, 12'd30, 16'h7777));
    tick();
    tick();
    bus_rst = 1'b1;
    tick();
    bus_rst = 1'b0;
    push_pair(12'd31, 16'h8888, 16'h0000);
    drain("t6r_drain");
    check_eq("t6r_seq", 32'(ifc.seq_err_cnt), 32'd0);
    check_eq("t6r_gap", 32'(ifc.gap_cnt), 32'd0);
    check_eq("t6r_fifo", 32'(fq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
